serial_tx_ctrl: RTL
===================

// Module: serial_tx_ctrl
// PURPOSE
//  Sequencer for the N-bit parallel-load / serial-out shift register. Accepts a
//  parallel word over a valid/ready handshake, pulses the register's load, then
//  paces shifts at one bit per DIV clocks, MSB first. Drives framing and done
//  strobes to the serial link, and enforces an idle gap between frames.
// PARAMETERS
//  N    12  data word width; must match the shift register width (N>=2)
//  DIV  4   clk cycles per serial bit period (DIV>=1)
//  GAP  1   idle bit periods after each frame (GAP>=0)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high
//  in_valid   in   1  upstream word valid
//  in_ready   out  1  controller accepts a word (IDLE only)
//  in_data    in   N  word to transmit
//  sr_load    out  1  shift register load strobe (one clk)
//  sr_d       out  N  shift register parallel data (captured word)
//  sr_shift   out  1  shift register advance strobe (one clk)
//  sr_sout    in   1  shift register serial out (q[N-1])
//  ser_out    out  1  serial line data
//  ser_frame  out  1  high while data/parity bits are on ser_out
//  busy       out  1  high in any state other than IDLE
//  done       out  1  one-clk pulse when a frame, including gap, completes
// BEHAVIOUR
//  All outputs registered except in_ready (= state==IDLE) and ser_out.
//  Reset (async, immediate): state=IDLE, counters=0, sr_d=0, sr_load=sr_shift=0,
//   ser_frame=busy=done=0, ser_out=0, in_ready=1. Reset mid-frame aborts frame.
//  FSM: IDLE -> LOAD -> SHIFT -> [PARITY] -> GAP -> IDLE.
//  IDLE: in_valid&&in_ready at edge T0: sr_d<=in_data; -> LOAD.
//  LOAD (1 clk, T1): sr_load=1; -> SHIFT.
//  SHIFT: bit counter b=0..N-1, divider d=0..DIV-1. ser_out=sr_sout, ser_frame=1.
//   Bit b occupies cycles T2+b*DIV .. T2+(b+1)*DIV-1. sr_shift=1 in the last
//   cycle of bits 0..N-2 (N-1 pulses per frame); none after bit N-1.
//   After bit N-1: -> PARITY if enabled, else GAP (or IDLE if GAP==0).
//  GAP: GAP*DIV cycles, ser_out=0, ser_frame=0, busy=1.
//  done pulses in the first IDLE cycle after a frame; next word may be accepted
//   in that same cycle (back-to-back, no extra bubble).
//  in_valid while busy: ignored, in_ready=0, in_data not sampled.
//  Counters wrap to 0 on each state change; no state is reachable with d>=DIV.
//  DIV==1: one bit per clk, sr_shift asserted every SHIFT cycle except the last.
//  Frame latency T0 -> done: 2 + (N + P + GAP)*DIV clks (P=1 with parity, else 0).
// CONFIGURATION
//  SERIAL_TX_CTRL_PARITY_EN defined: even-parity bit (^sr_d) is sent for one
//   bit period after bit N-1, state PARITY, ser_frame=1, ser_out=^sr_d.
//  Undefined: PARITY state and parity logic absent; SHIFT goes to GAP directly.
// TESTING (N=12, DIV=4, GAP=1 unless stated)
//  1 in_data=0xA5C at T0 -> sr_load at T1 only; ser_out 1010_0101_1100 each bit 4
//    clks from T2; 11 sr_shift pulses; ser_frame high 48 clks; done at T0+54.
//  2 parity build, in_data=0xA5C -> 13th bit = 0 for 4 clks; done at T0+58;
//    in_data=0x001 -> parity bit 1.
//  3 in_valid held high with 2 words -> second accepted on the done cycle;
//    in_ready=0 and in_data changes ignored throughout frame 1.
//  4 reset asserted mid-SHIFT (bit 5) -> outputs to reset values immediately,
//    no done pulse, in_ready=1 after release; new word transmits cleanly.
//  5 DIV=1, GAP=0, in_data=0xFFF -> ser_out 12 consecutive 1s T2..T13,
//    sr_shift high T2..T12, done at T14.
//  6 Sweep N=2, DIV=3, GAP=2 -> frame timing matches latency formula exactly.

Source files
------------

// File: rtl/serial_tx_ctrl.sv
// Serial transmit sequencer for an N-bit PISO shift register, MSB first.
// Optional even parity bit: define SERIAL_TX_CTRL_PARITY_EN.
module serial_tx_ctrl #(
  parameter int N   = 12,
  parameter int DIV = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         sr_load,
  output logic [N-1:0] sr_d,
  output logic         sr_shift,
  input  logic         sr_sout,
  output logic         ser_out,
  output logic         ser_frame,
  output logic         busy,
  output logic         done
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] BMAX = BW'(N - 1);
  localparam logic [DW-1:0] DMAX = DW'(DIV - 1);
  localparam logic [GW-1:0] GMAX = GW'((GAP > 0) ? GAP - 1 : 0);

`ifdef SERIAL_TX_CTRL_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_PAR, S_GAP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_GAP
  } state_t;
`endif

  state_t        state_q;
  logic [BW-1:0] b_q;
  logic [DW-1:0] d_q;
  logic [GW-1:0] g_q;
  logic [N-1:0]  sr_d_q;
  logic          sr_load_q;
  logic          sr_shift_q;
  logic          ser_frame_q;
  logic          busy_q;
  logic          done_q;

  assign in_ready  = (state_q == S_IDLE);
  assign sr_load   = sr_load_q;
  assign sr_d      = sr_d_q;
  assign sr_shift  = sr_shift_q;
  assign ser_frame = ser_frame_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Frame sequencer; strobes are computed one edge ahead so they are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      b_q         <= '0;
      d_q         <= '0;
      g_q         <= '0;
      sr_d_q      <= '0;
      sr_load_q   <= 1'b0;
      sr_shift_q  <= 1'b0;
      ser_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      sr_load_q  <= 1'b0;
      sr_shift_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            sr_d_q    <= in_data;
            sr_load_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          state_q     <= S_SHIFT;
          b_q         <= '0;
          d_q         <= '0;
          ser_frame_q <= 1'b1;
          sr_shift_q  <= (DIV == 1);
        end
        S_SHIFT: begin
          if (d_q != DMAX) begin
            d_q        <= d_q + DW'(1);
            sr_shift_q <= (d_q + DW'(1) == DMAX)
                          && (b_q != BMAX);
          end else if (b_q != BMAX) begin
            b_q        <= b_q + BW'(1);
            d_q        <= '0;
            sr_shift_q <= (DIV == 1)
                          && (b_q + BW'(1) != BMAX);
          end else begin
            b_q <= '0;
            d_q <= '0;
`ifdef SERIAL_TX_CTRL_PARITY_EN
            state_q <= S_PAR;
`else
            ser_frame_q <= 1'b0;
            if (GAP > 0) begin
              g_q     <= '0;
              state_q <= S_GAP;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
`endif
          end
        end
`ifdef SERIAL_TX_CTRL_PARITY_EN
        S_PAR: begin
          if (d_q != DMAX) begin
            d_q <= d_q + DW'(1);
          end else begin
            d_q         <= '0;
            ser_frame_q <= 1'b0;
            if (GAP > 0) begin
              g_q     <= '0;
              state_q <= S_GAP;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
`endif
        S_GAP: begin
          if (d_q != DMAX) begin
            d_q <= d_q + DW'(1);
          end else if (g_q != GMAX) begin
            g_q <= g_q + GW'(1);
            d_q <= '0;
          end else begin
            d_q     <= '0;
            g_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line data: register output while shifting, parity bit, else idle low.
  always_comb begin
    ser_out = 1'b0;
    if (state_q == S_SHIFT) ser_out = sr_sout;
`ifdef SERIAL_TX_CTRL_PARITY_EN
    if (state_q == S_PAR) ser_out = ^sr_d_q;
`endif
  end

endmodule
